// File: rtl/audio_pkg.sv
// Shared types and helpers for the microphone front-end control path.
package audio_pkg;

  localparam int AUDIO_W = 16;

  typedef logic signed [AUDIO_W-1:0] audio_sample_t;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    CAL    = 2'd1,
    RUN    = 2'd2
  } cal_state_t;

  // Clamp a 17-bit difference into the signed 16-bit sample range.
  function automatic audio_sample_t sat16(input logic signed [AUDIO_W:0] v);
    if (v > 17'sd32767) begin
      sat16 = 16'sh7FFF;
    end else if (v < -17'sd32768) begin
      sat16 = 16'sh8000;
    end else begin
      sat16 = v[AUDIO_W-1:0];
    end
  endfunction

endpackage

// File: rtl/offset_accumulator.sv
// Sums 2^LOG2_CAL samples and reports their floor mean on the final sample.
module offset_accumulator
  import audio_pkg::*;
#(
  parameter int LOG2_CAL = 10
) (
  input  logic          audio_clk,
  input  logic          clear,
  input  logic          add_en,
  input  audio_sample_t sample,
  output logic          done,
  output audio_sample_t mean
);

  localparam int AW = AUDIO_W + LOG2_CAL;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic [LOG2_CAL-1:0]  count;

  // The mean includes the sample being added this cycle, so it is taken from sum.
  assign sum  = acc + AW'(sample);
  assign mean = AUDIO_W'(sum >>> LOG2_CAL);
  assign done = add_en && (count == '1);

  always_ff @(posedge audio_clk) begin
    if (clear) begin
      acc   <= '0;
      count <= '0;
    end else if (add_en) begin
      if (done) begin
        acc   <= '0;
        count <= '0;
      end else begin
        acc   <= sum;
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_cal_sequencer.sv
// Power-up settling, DC-offset calibration and DC-blocked streaming with a
// decimation strobe; recalibration runs in the background on request.
module audio_cal_sequencer
  import audio_pkg::*;
#(
  parameter int SETTLE_SAMPLES = 1024,
  parameter int LOG2_CAL       = 10,
  parameter int DECIM          = 2
) (
  input  logic               audio_clk,
  input  logic               rst_in,
  input  logic               mic_data_valid,
  input  logic signed [15:0] audio_in,
  input  logic               recal_req,
  output logic signed [15:0] dc_out,
  output logic               dc_valid,
  output logic               decim_strobe,
  output logic signed [15:0] offset,
  output logic               offset_valid,
  output logic               busy,
  output logic [1:0]         state_out
);

  localparam logic [1:0] ST_SETTLE = SETTLE;
  localparam logic [1:0] ST_CAL    = CAL;
  localparam logic [1:0] ST_RUN    = RUN;

  localparam int SW = $clog2(SETTLE_SAMPLES + 1);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [1:0]          state;
  logic [SW-1:0]       settle_cnt;
  logic [DW-1:0]       decim_cnt;
  logic                settle_done;
  logic                cal_clear;
  logic                cal_add;
  logic                cal_done;
  logic                out_en;
  audio_sample_t       cal_mean;
  logic signed [16:0]  diff;

  assign settle_done = (state == ST_SETTLE) && mic_data_valid &&
                       (settle_cnt == SW'(SETTLE_SAMPLES - 1));
  assign cal_clear   = rst_in || settle_done || ((state == ST_RUN) && recal_req);
  assign cal_add     = !rst_in && (state == ST_CAL) && mic_data_valid;
  // Output keeps flowing during a recalibration once any offset exists.
  assign out_en      = mic_data_valid && offset_valid;
  assign diff        = $signed({audio_in[15], audio_in}) - $signed({offset[15], offset});

  assign busy      = (state != ST_RUN);
  assign state_out = state;

  offset_accumulator #(
    .LOG2_CAL(LOG2_CAL)
  ) u_offset_accumulator (
    .audio_clk(audio_clk),
    .clear    (cal_clear),
    .add_en   (cal_add),
    .sample   (audio_in),
    .done     (cal_done),
    .mean     (cal_mean)
  );

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      state      <= ST_SETTLE;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_SETTLE: begin
          if (settle_done) begin
            state      <= ST_CAL;
            settle_cnt <= '0;
          end else if (mic_data_valid) begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_CAL: begin
          if (cal_done) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (recal_req) begin
            state <= ST_CAL;
          end
        end
        default: state <= ST_SETTLE;
      endcase
    end
  end

  // The sample that completes a calibration is still corrected with the old offset.
  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      offset       <= '0;
      offset_valid <= 1'b0;
    end else if (cal_done) begin
      offset       <= cal_mean;
      offset_valid <= 1'b1;
    end
  end

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      dc_out       <= '0;
      dc_valid     <= 1'b0;
      decim_strobe <= 1'b0;
      decim_cnt    <= '0;
    end else begin
      dc_valid     <= out_en;
      decim_strobe <= out_en && (decim_cnt == '0);
      if (out_en) begin
        dc_out    <= sat16(diff);
        decim_cnt <= (decim_cnt == DW'(DECIM - 1)) ? '0 : decim_cnt + 1'b1;
      end else if (cal_done && !offset_valid) begin
        // Phase is only realigned on the first calibration after reset.
        decim_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_audio_cal_sequencer.sv
// Directed bench with a scoreboard for the DC-blocked output stream.
module tb_audio_cal_sequencer;

  localparam int SETTLE_SAMPLES = 4;
  localparam int LOG2_CAL       = 2;
  localparam int DECIM          = 3;

  logic               audio_clk = 1'b0;
  logic               rst_in = 1'b1;
  logic               mic_data_valid = 1'b0;
  logic signed [15:0] audio_in = '0;
  logic               recal_req = 1'b0;
  logic signed [15:0] dc_out;
  logic               dc_valid;
  logic               decim_strobe;
  logic signed [15:0] offset;
  logic               offset_valid;
  logic               busy;
  logic [1:0]         state_out;

  audio_cal_sequencer #(
    .SETTLE_SAMPLES(SETTLE_SAMPLES),
    .LOG2_CAL      (LOG2_CAL),
    .DECIM         (DECIM)
  ) dut (
    .audio_clk     (audio_clk),
    .rst_in        (rst_in),
    .mic_data_valid(mic_data_valid),
    .audio_in      (audio_in),
    .recal_req     (recal_req),
    .dc_out        (dc_out),
    .dc_valid      (dc_valid),
    .decim_strobe  (decim_strobe),
    .offset        (offset),
    .offset_valid  (offset_valid),
    .busy          (busy),
    .state_out     (state_out)
  );

  always #5 audio_clk = ~audio_clk;

  typedef struct {
    logic signed [15:0] data;
    logic               strobe;
    int                 due;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_cnt = 0;
  bit   mon_en = 1'b0;

  // Reference model of the sequencer, advanced when stimulus is driven.
  int m_state, m_settle, m_sum, m_n, m_off, m_dcnt;
  bit m_offv;

  always @(posedge audio_clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_div(input int num, input int den);
    int q;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic modelReset();
    m_state = 0; m_settle = 0; m_sum = 0; m_n = 0;
    m_off = 0; m_offv = 1'b0; m_dcnt = 0;
    sb.delete();
  endtask

  task automatic applyStimulus(input logic v, input logic signed [15:0] x, input logic req);
    exp_t e;
    mic_data_valid = v;
    audio_in       = x;
    recal_req      = req;
    if (v && m_offv) begin
      e.data   = 16'(clamp16(int'(x) - m_off));
      e.strobe = (m_dcnt == 0);
      e.due    = edge_cnt + 1;
      sb.push_back(e);
      m_dcnt = (m_dcnt + 1) % DECIM;
    end
    case (m_state)
      0: if (v) begin
        m_settle++;
        if (m_settle == SETTLE_SAMPLES) begin
          m_state = 1; m_settle = 0; m_sum = 0; m_n = 0;
        end
      end
      1: if (v) begin
        m_sum += int'(x);
        m_n++;
        if (m_n == (1 << LOG2_CAL)) begin
          m_off   = floor_div(m_sum, 1 << LOG2_CAL);
          m_offv  = 1'b1;
          m_state = 2;
        end
      end
      default: if (req) begin
        m_state = 1; m_sum = 0; m_n = 0;
      end
    endcase
    @(posedge audio_clk);
    #1;
    mic_data_valid = 1'b0;
    recal_req      = 1'b0;
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_dc_out"}, dc_out, 0);
    checkOutput({pfx, "_dc_valid"}, dc_valid, 0);
    checkOutput({pfx, "_decim_strobe"}, decim_strobe, 0);
    checkOutput({pfx, "_offset"}, offset, 0);
    checkOutput({pfx, "_offset_valid"}, offset_valid, 0);
    checkOutput({pfx, "_busy"}, busy, 1);
    checkOutput({pfx, "_state"}, state_out, 0);
  endtask

  // Reset is held with a live sample and request to show reset takes priority.
  task automatic resetDut(input string pfx);
    mon_en = 1'b0;
    rst_in = 1'b1;
    mic_data_valid = 1'b1;
    audio_in = 16'sd1234;
    recal_req = 1'b1;
    modelReset();
    repeat (2) @(posedge audio_clk);
    #1;
    checkResetValues(pfx);
    mic_data_valid = 1'b0;
    recal_req = 1'b0;
    rst_in = 1'b0;
    mon_en = 1'b1;
  endtask

  always @(negedge audio_clk) begin : monitor
    bit due;
    if (mon_en && !rst_in) begin
      due = (sb.size() > 0) && (sb[0].due == edge_cnt);
      checkOutput("dc_valid", dc_valid, due);
      if (due) begin
        if (dc_valid) begin
          checkOutput("dc_out", dc_out, sb[0].data);
          checkOutput("decim_strobe", decim_strobe, sb[0].strobe);
        end
        void'(sb.pop_front());
      end else begin
        checkOutput("decim_strobe_idle", decim_strobe, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetDut("rst0");

    applyStimulus(1'b1, 16'sd100, 1'b0);
    applyStimulus(1'b1, 16'sd100, 1'b0);
    applyStimulus(1'b0, 16'sd0, 1'b1);
    applyStimulus(1'b1, 16'sd100, 1'b0);
    applyStimulus(1'b1, 16'sd100, 1'b0);
    checkOutput("settle_to_cal_state", state_out, 1);
    checkOutput("settle_to_cal_busy", busy, 1);

    repeat (4) applyStimulus(1'b1, 16'sd100, 1'b0);
    checkOutput("cal1_offset", offset, 100);
    checkOutput("cal1_offset_valid", offset_valid, 1);
    checkOutput("cal1_state", state_out, 2);
    checkOutput("cal1_busy", busy, 0);

    applyStimulus(1'b1, 16'sd100, 1'b0);
    applyStimulus(1'b1, 16'sd120, 1'b0);
    applyStimulus(1'b1, 16'sd80, 1'b0);
    applyStimulus(1'b1, -16'sd5, 1'b0);
    applyStimulus(1'b1, 16'sd300, 1'b0);

    applyStimulus(1'b1, 16'sd7, 1'b1);
    checkOutput("recal_rnd_state", state_out, 1);
    checkOutput("recal_rnd_busy", busy, 1);
    applyStimulus(1'b1, -16'sd1, 1'b0);
    applyStimulus(1'b1, -16'sd1, 1'b0);
    applyStimulus(1'b1, -16'sd1, 1'b0);
    applyStimulus(1'b1, -16'sd2, 1'b0);
    checkOutput("round_offset", offset, -2);

    applyStimulus(1'b0, 16'sd0, 1'b1);
    repeat (4) applyStimulus(1'b1, -16'sd100, 1'b0);
    checkOutput("neg_offset", offset, -100);
    applyStimulus(1'b1, -16'sd32768, 1'b0);
    applyStimulus(1'b1, 16'sd32767, 1'b0);

    applyStimulus(1'b0, 16'sd0, 1'b1);
    repeat (4) applyStimulus(1'b1, 16'sd100, 1'b0);
    checkOutput("pos_offset", offset, 100);
    applyStimulus(1'b1, -16'sd32768, 1'b0);

    applyStimulus(1'b1, 16'sd10, 1'b1);
    checkOutput("recal50_busy", busy, 1);
    applyStimulus(1'b1, 16'sd50, 1'b0);
    applyStimulus(1'b1, 16'sd50, 1'b0);
    applyStimulus(1'b0, 16'sd0, 1'b1);
    applyStimulus(1'b1, 16'sd50, 1'b0);
    checkOutput("recal50_old_offset", offset, 100);
    applyStimulus(1'b1, 16'sd50, 1'b0);
    checkOutput("recal50_offset", offset, 50);
    checkOutput("recal50_state", state_out, 2);

    applyStimulus(1'b0, 16'sd0, 1'b1);
    applyStimulus(1'b1, 16'sd50, 1'b0);
    applyStimulus(1'b1, 16'sd50, 1'b0);
    resetDut("rst1");

    repeat (4) applyStimulus(1'b1, 16'sd7, 1'b0);
    checkOutput("resettle_state", state_out, 1);
    checkOutput("resettle_offset_valid", offset_valid, 0);
    repeat (4) applyStimulus(1'b1, 16'sd7, 1'b0);
    checkOutput("cal2_offset", offset, 7);
    applyStimulus(1'b1, 16'sd9, 1'b0);
    applyStimulus(1'b1, 16'sd9, 1'b0);

    repeat (3) applyStimulus(1'b0, 16'sd0, 1'b0);
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_cal_sequencer.md
# audio_cal_sequencer

Control block for the microphone front end, running on the audio clock. It sequences power-up settling and DC-offset calibration, then runs the DC-blocked sample stream with a decimation strobe. It supports recalibration on request without interrupting the output stream. It sits between the mic deserializer (`mic_data_valid`, raw samples) and the anti-alias FIR / decimation stage, and replaces ad-hoc offset triggering with an explicit state machine.

## Interface
Parameters:
- `SETTLE_SAMPLES`, 1024: valid samples discarded after reset before calibration starts (≥1).
- `LOG2_CAL`, 10: calibration averages 2^LOG2_CAL samples (1..16).
- `DECIM`, 2: decimation ratio for `decim_strobe` (≥1).

Ports:
- `audio_clk`, in, 1: sole clock.
- `rst_in`, in, 1: reset, synchronous, active-high.
- `mic_data_valid`, in, 1: one-cycle strobe; `audio_in` valid.
- `audio_in`, in, 16 signed: raw mic sample.
- `recal_req`, in, 1: one-cycle request to recalibrate.
- `dc_out`, out, 16 signed: offset-corrected sample.
- `dc_valid`, out, 1: one-cycle strobe qualifying `dc_out`.
- `decim_strobe`, out, 1: high with every DECIM-th `dc_valid`.
- `offset`, out, 16 signed: offset currently applied.
- `offset_valid`, out, 1: at least one calibration has completed since reset.
- `busy`, out, 1: state is SETTLE or CAL.
- `state_out`, out, 2: current state encoding, for debug.

## Operation
- States: SETTLE=0, CAL=1, RUN=2.
- Reset enters SETTLE.
- SETTLE:
  - Count valid samples.
  - After the `SETTLE_SAMPLES`-th sample, go to CAL with the accumulator and sample counter cleared.
- CAL:
  - Add sign-extended `audio_in` into a (16+LOG2_CAL)-bit accumulator on each valid sample.
  - On the 2^LOG2_CAL-th sample, compute new offset = accumulator (including that sample) >>> LOG2_CAL. This is an arithmetic shift, truncating toward −∞, and the result is the low 16 bits.
  - Load `offset`, set `offset_valid`, go to RUN.
- RUN:
  - On each valid sample, `dc_out` = sat16(`audio_in` − `offset`), computed at 17 bits.
  - Saturation: results above 32767 become 32767; results below −32768 become −32768.
  - Pulse `dc_valid`.
- Decimation:
  - A modulo-DECIM counter advances on each `dc_valid`.
  - It is cleared on entry to RUN from CAL, and only on the first entry after reset.
  - `decim_strobe` fires when the counter is 0, so the first sample after calibration strobes.
- Recalibration:
  - `recal_req` in RUN goes directly to CAL; SETTLE is skipped.
  - During that CAL, output continues: `dc_out`/`dc_valid` keep using the old offset, and the decimation phase is preserved.
  - The new offset swaps atomically at completion. The sample completing calibration is still corrected with the old offset.
- Before the first calibration completes, `dc_valid` and `decim_strobe` stay 0.
- `recal_req` outside RUN is ignored; it is not queued.

## Timing
- Reset values:
  - `dc_out` = 0, `dc_valid` = 0, `decim_strobe` = 0.
  - `offset` = 0, `offset_valid` = 0, `busy` = 1, `state_out` = 0.
  - All counters and the accumulator are 0.
- Latency: `dc_valid`/`dc_out` are registered, 1 cycle after `mic_data_valid`. `decim_strobe` is coincident with `dc_valid`.
- `offset`/`offset_valid` update 1 cycle after the final calibration sample. `state_out` shows RUN in the same cycle.
- `recal_req` in RUN: state is CAL on the next cycle. A sample arriving in the same cycle as the request is not accumulated, but it is still output.
- `rst_in` mid-CAL or mid-RUN aborts immediately:
  - The partial accumulation is discarded and the offset is cleared.
  - Reset wins over any simultaneous valid sample or `recal_req`.
- `mic_data_valid` can arrive on consecutive cycles; every sample is processed without stalls.

## Structure
- Shared package `audio_pkg` holds:
  - `audio_sample_t` (logic signed [15:0]).
  - `cal_state_t` enum {SETTLE, CAL, RUN} as 2 bits.
  - `AUDIO_W` = 16.
  - The `sat16` function.
- Sub-module `offset_accumulator`:
  - Inputs: clear, add-enable, sample.
  - Outputs: done pulse, mean.
  - Parameterised by LOG2_CAL; owns the accumulator and sample counter.
- The top level holds the FSM, the settle and decimation counters, and the correction/saturation register.

## Test plan
- Settling and first calibration, SETTLE_SAMPLES=4, LOG2_CAL=2, constant input 100:
  - No `dc_valid` during the first 8 samples; `offset` = 100 after the 8th.
  - The next sample of 100 gives `dc_out` = 0.
- Rounding: calibration samples {−1,−1,−1,−2} → `offset` = −2 (floor of −5/4).
- Saturation: offset −100 with input −32768 → −32668; offset 100 with input −32768 → −32768 clamped.
- Decimation, DECIM=3 with back-to-back valids:
  - `decim_strobe` on `dc_valid` #1, #4, #7.
  - Recalibration mid-stream does not shift this phase.
- Recalibration: in RUN, pulse `recal_req`, then feed 4 samples of 50.
  - `busy` goes 1, and output continues with the old offset.
  - `offset` becomes 50 after the 4th sample; `recal_req` pulses during CAL are ignored.
- Reset mid-CAL after 2 samples: all outputs return to reset values, and the full SETTLE sequence repeats.
